// File: rtl/multi_blit_engine_if.sv
// Sprite-memory read port and framebuffer write port of the blit engine.
// The engine drives the master side; memory and framebuffer sit on the slave side.
interface multi_blit_engine_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned X_W    = 10
);
  logic [ADDR_W-1:0] src_addr;
  logic              src_re;
  logic [PIX_W-1:0]  src_rdata;
  logic [X_W-1:0]    fb_writex;
  logic [X_W-1:0]    fb_writey;
  logic [PIX_W-1:0]  fb_writepixel;
  logic              fb_we;

  modport master (
    output src_addr, src_re, fb_writex, fb_writey, fb_writepixel, fb_we,
    input  src_rdata
  );

  modport slave (
    input  src_addr, src_re, fb_writex, fb_writey, fb_writepixel, fb_we,
    output src_rdata
  );
endinterface

// File: rtl/multi_blit_engine.sv
// Multi-channel blitter: copies a linear range of sprite words into a framebuffer rectangle,
// with per-channel request latching, round-robin grant, colour keying and screen clipping.
module multi_blit_engine #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned X_W    = 10,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [NCH-1:0]        ch_run,
  input  logic [NCH*ADDR_W-1:0] ch_start,
  input  logic [NCH*ADDR_W-1:0] ch_end,
  input  logic [NCH*X_W-1:0]    ch_ox,
  input  logic [NCH*X_W-1:0]    ch_oy,
  input  logic [NCH*X_W-1:0]    ch_width,
  input  logic [NCH-1:0]        ch_key_en,
  input  logic [PIX_W-1:0]      key_color,
  input  logic                  abort,
  multi_blit_engine_if.master   bus,
  output logic [NCH-1:0]        ch_busy,
  output logic [NCH-1:0]        ch_done
);
  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  logic [ADDR_W-1:0] start_q [NCH];
  logic [ADDR_W-1:0] end_q   [NCH];
  logic [X_W-1:0]    ox_q    [NCH];
  logic [X_W-1:0]    oy_q    [NCH];
  logic [X_W-1:0]    width_q [NCH];
  logic [NCH-1:0]    key_q, pend_q, pend_clr;

  state_e            state_q, state_d;
  logic [GW-1:0]     g_q, g_d, last_q, last_d, sel;
  logic              sel_vld;
  logic [ADDR_W-1:0] cur_q, cur_d, stop_q, stop_d;
  logic [X_W-1:0]    col_q, col_d, row_q, row_d;
  logic [X_W-1:0]    aox_q, aox_d, aoy_q, aoy_d, aw_q, aw_d;
  logic              akey_q, akey_d;
  logic              re_q, re_d, wr_q, wr_d, clip_q, clip_d;
  logic [X_W-1:0]    wx_q, wx_d, wy_q, wy_d, tx, ty;
  logic [NCH-1:0]    done_q, done_d;
  logic              abort_hit;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int unsigned k);
    int unsigned s;
    s = (32'(base) + k) % NCH;
    return s[GW-1:0];
  endfunction

  // Search starts one past the last channel served.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      if (!sel_vld && pend_q[rr_idx(last_q, k)]) begin
        sel     = rr_idx(last_q, k);
        sel_vld = 1'b1;
      end
    end
  end

  assign abort_hit = abort && (state_q == StRun || state_q == StFlush);

  always_comb begin
    pend_clr = '0;
    if (state_q == StDone || abort_hit) pend_clr[g_q] = 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pend_q <= '0;
      key_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
        ox_q[i]    <= '0;
        oy_q[i]    <= '0;
        width_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_run[i] && !pend_q[i]) begin
          pend_q[i]  <= 1'b1;
          start_q[i] <= ch_start[i*ADDR_W +: ADDR_W];
          end_q[i]   <= ch_end[i*ADDR_W +: ADDR_W];
          ox_q[i]    <= ch_ox[i*X_W +: X_W];
          oy_q[i]    <= ch_oy[i*X_W +: X_W];
          width_q[i] <= ch_width[i*X_W +: X_W];
          key_q[i]   <= ch_key_en[i];
        end else if (pend_clr[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  assign tx = aox_q + col_q;
  assign ty = aoy_q + row_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cur_d   = cur_q;
    stop_d  = stop_q;
    col_d   = col_q;
    row_d   = row_q;
    aox_d   = aox_q;
    aoy_d   = aoy_q;
    aw_d    = aw_q;
    akey_d  = akey_q;
    re_d    = 1'b0;
    wr_d    = 1'b0;
    clip_d  = clip_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    done_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (sel_vld) begin
          g_d    = sel;
          cur_d  = start_q[sel];
          stop_d = end_q[sel];
          aox_d  = ox_q[sel];
          aoy_d  = oy_q[sel];
          aw_d   = width_q[sel];
          akey_d = key_q[sel];
          col_d  = '0;
          row_d  = '0;
          // Empty requests pass through an idle flush cycle so done lands at grant+2.
          if (start_q[sel] > end_q[sel] || width_q[sel] == '0) begin
            state_d = StFlush;
          end else begin
            state_d = StRun;
            re_d    = 1'b1;
          end
        end
      end
      StRun: begin
        wx_d   = tx;
        wy_d   = ty;
        clip_d = (32'(tx) >= H_RES) || (32'(ty) >= V_RES);
        if (abort) begin
          state_d = StIdle;
        end else begin
          wr_d = 1'b1;
          if (col_q == aw_q - X_W'(1)) begin
            col_d = '0;
            row_d = row_q + X_W'(1);
          end else begin
            col_d = col_q + X_W'(1);
          end
          if (cur_q == stop_q) begin
            state_d = StFlush;
          end else begin
            cur_d = cur_q + ADDR_W'(1);
            re_d  = 1'b1;
          end
        end
      end
      StFlush: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          state_d     = StDone;
          done_d[g_q] = 1'b1;
        end
      end
      StDone: begin
        last_d  = g_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
      g_q     <= '0;
      last_q  <= GW'(NCH - 1);
      cur_q   <= '0;
      stop_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      aox_q   <= '0;
      aoy_q   <= '0;
      aw_q    <= '0;
      akey_q  <= 1'b0;
      re_q    <= 1'b0;
      wr_q    <= 1'b0;
      clip_q  <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      stop_q  <= stop_d;
      col_q   <= col_d;
      row_q   <= row_d;
      aox_q   <= aox_d;
      aoy_q   <= aoy_d;
      aw_q    <= aw_d;
      akey_q  <= akey_d;
      re_q    <= re_d;
      wr_q    <= wr_d;
      clip_q  <= clip_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      done_q  <= done_d;
    end
  end

  assign bus.src_re    = re_q;
  assign bus.src_addr  = cur_q;
  assign bus.fb_writex = wx_q;
  assign bus.fb_writey = wy_q;
  // Read data returns in the write cycle itself, so pixel and key compare use it directly.
  assign bus.fb_writepixel = wr_q ? bus.src_rdata : '0;
  assign bus.fb_we = wr_q && !clip_q && !(akey_q && bus.src_rdata == key_color);

  assign ch_busy = pend_q;
  assign ch_done = done_q;
endmodule
